// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a pending-write scoreboard.
//   Two asynchronous read ports, one synchronous write port, optional
//   hardwired zero register and optional write-to-read bypass. A busy bit per
//   register tracks issued-but-not-written-back destinations for the hazard
//   unit; pend_cnt is a registered population count of those bits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   adr1/adr2           read addresses; rs1/rs2 read data (combinational)
//   rs1_busy/rs2_busy   pending-write flag of the addressed register
//   issue_en/issue_rd   mark issue_rd as pending
//   en/wa/wd            writeback enable, address, data
//   flush               cancel all pending marks
//   pend_cnt            number of busy bits set (lags by one cycle)
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   adr1,
  input  logic [AW-1:0]   adr2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            en,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            flush,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;
  logic             wr_ok;
  logic             iss_ok;

  // Register 0 is excluded from writes and issues only when it is hardwired.
  assign wr_ok  = en && ((wa != '0) || (ZERO_REG == 0));
  assign iss_ok = issue_en && ((issue_rd != '0) || (ZERO_REG == 0));

  // Scoreboard next state: flush beats everything, then the writeback clear,
  // then the issue set so a new producer to the same register wins.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_ok)  busy_next[wa]       = 1'b0;
      if (iss_ok) busy_next[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) regs[wa] <= wd;
      busy     <= busy_next;
      pend_cnt <= cnt_next;
    end
  end

  // Read port 1: a same-cycle writeback to the addressed register forwards
  // its data and hides the pending bit it is about to clear.
  always_comb begin
    rs1      = regs[adr1];
    rs1_busy = busy[adr1];
    if ((BYPASS != 0) && wr_ok && (wa == adr1)) begin
      rs1      = wd;
      rs1_busy = 1'b0;
    end
    if ((ZERO_REG != 0) && (adr1 == '0)) begin
      rs1      = '0;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2      = regs[adr2];
    rs2_busy = busy[adr2];
    if ((BYPASS != 0) && wr_ok && (wa == adr2)) begin
      rs2      = wd;
      rs2_busy = 1'b0;
    end
    if ((ZERO_REG != 0) && (adr2 == '0)) begin
      rs2      = '0;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   adr1 = '0, adr2 = '0, issue_rd = '0, wa = '0;
  logic            issue_en = 1'b0, en = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] wd = '0;

  logic [XLEN-1:0] rs1_a, rs2_a, rs1_b, rs2_b;
  logic            rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b;
  logic [AW:0]     pend_a, pend_b;

  always #5 clk = ~clk;

  // a: hardwired zero + bypass; b: plain register 0, no bypass
  regfile_sb dut_a (
    .clk(clk), .rst(rst), .adr1(adr1), .adr2(adr2), .rs1(rs1_a), .rs2(rs2_a),
    .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a), .issue_en(issue_en),
    .issue_rd(issue_rd), .en(en), .wa(wa), .wd(wd), .flush(flush),
    .pend_cnt(pend_a));

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .adr1(adr1), .adr2(adr2), .rs1(rs1_b), .rs2(rs2_b),
    .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .issue_en(issue_en),
    .issue_rd(issue_rd), .en(en), .wa(wa), .wd(wd), .flush(flush),
    .pend_cnt(pend_b));

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; issue_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adr1 = 5'd5; adr2 = 5'd9;
    step();
    rst = 1'b0;
    q.push_back('{"rst_rs1_a", 32'h0});
    q.push_back('{"rst_rs2_a", 32'h0});
    q.push_back('{"rst_busy_a", 32'h0});
    q.push_back('{"rst_pend_a", 32'h0});
    q.push_back('{"rst_pend_b", 32'h0});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs2_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs2_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'({rs1_busy_a, rs2_busy_a}) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, {rs1_busy_a, rs2_busy_a}, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(pend_b) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_b, e.exp); end
  endtask

  task automatic test_write_bypass();
    step();
    en = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; adr1 = 5'd5; adr2 = 5'd5;
    q.push_back('{"byp_rs1_a_same", 32'hDEADBEEF});
    q.push_back('{"byp_rs2_a_same", 32'hDEADBEEF});
    q.push_back('{"nobyp_rs1_b_same", 32'h0});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs2_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs2_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs1_b !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_b, e.exp); end
    step();
    idle();
    q.push_back('{"byp_rs1_a_next", 32'hDEADBEEF});
    q.push_back('{"nobyp_rs1_b_next", 32'hDEADBEEF});
    q.push_back('{"nobyp_rs2_b_next", 32'hDEADBEEF});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs1_b !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_b, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs2_b !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs2_b, e.exp); end
  endtask

  task automatic test_zero_reg();
    step();
    en = 1'b1; wa = 5'd0; wd = 32'h12345678; adr1 = 5'd0;
    q.push_back('{"zero_rs1_a_same", 32'h0});
    q.push_back('{"zero_busy_a_same", 32'h0});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
    step();
    idle();
    q.push_back('{"zero_rs1_a_next", 32'h0});
    q.push_back('{"nozero_rs1_b_next", 32'h12345678});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs1_b !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_b, e.exp); end
  endtask

  task automatic test_scoreboard();
    logic [4:0] rds [3];
    rds = '{5'd3, 5'd7, 5'd9};
    step();
    for (int i = 0; i < 3; i++) begin
      issue_en = 1'b1; issue_rd = rds[i];
      step();
      q.push_back('{$sformatf("issue_pend_%0d", i + 1), 32'(i + 1)});
      if (i == 2) begin issue_en = 1'b0; adr1 = 5'd7; end
      @(negedge clk);
      e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    end
    q.push_back('{"busy7_a", 32'h1});
    q.push_back('{"busy7_b", 32'h1});
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_b) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_b, e.exp); end
    step();
    en = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
    q.push_back('{"wb7_busy_a_hidden", 32'h0});
    q.push_back('{"wb7_busy_b_visible", 32'h1});
    q.push_back('{"wb7_rs1_a", 32'h0000_0077});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_b) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_b, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
    step();
    idle();
    q.push_back('{"wb7_pend_a", 32'd2});
    q.push_back('{"wb7_busy_a_after", 32'h0});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
  endtask

  task automatic test_same_cycle();
    step();
    issue_en = 1'b1; issue_rd = 5'd4;
    step();
    idle();
    q.push_back('{"issue4_pend", 32'd3});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    step();
    issue_en = 1'b1; issue_rd = 5'd4; en = 1'b1; wa = 5'd4; wd = 32'h4444_4444; adr1 = 5'd4;
    step();
    idle();
    q.push_back('{"same4_pend", 32'd3});
    q.push_back('{"same4_busy", 32'h1});
    q.push_back('{"same4_data", 32'h4444_4444});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
  endtask

  task automatic test_flush();
    step();
    flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd10;
    en = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    step();
    idle();
    adr1 = 5'd10; adr2 = 5'd3;
    q.push_back('{"flush_pend_a", 32'd0});
    q.push_back('{"flush_pend_b", 32'd0});
    q.push_back('{"flush_busy10", 32'h0});
    q.push_back('{"flush_rs2_reg3", 32'hA5A5A5A5});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(pend_b) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_b, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(rs1_busy_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_busy_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (rs2_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs2_a, e.exp); end
  endtask

  task automatic test_reset_mid();
    step();
    for (int i = 1; i < 8; i++) begin
      en = 1'b1; wa = 5'(i); wd = 32'h1000_0000 + 32'(i);
      issue_en = 1'b1; issue_rd = 5'(i);
      step();
    end
    idle();
    q.push_back('{"fill_pend", 32'd7});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    step();
    rst = 1'b1; en = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF; issue_en = 1'b1; issue_rd = 5'd12;
    step();
    idle();
    q.push_back('{"rstmid_pend_a", 32'd0});
    q.push_back('{"rstmid_pend_b", 32'd0});
    @(negedge clk);
    e = q.pop_front(); n_cmp++; if (32'(pend_a) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_a, e.exp); end
    e = q.pop_front(); n_cmp++; if (32'(pend_b) !== e.exp) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.name, pend_b, e.exp); end
    for (int r = 0; r < 32; r++) begin
      adr1 = 5'(r); adr2 = 5'(31 - r);
      q.push_back('{$sformatf("rstmid_data_a_r%0d", r), 32'h0});
      q.push_back('{$sformatf("rstmid_data_b_r%0d", r), 32'h0});
      q.push_back('{$sformatf("rstmid_busy_r%0d", r), 32'h0});
      #1;
      e = q.pop_front(); n_cmp++; if (rs1_a !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_a, e.exp); end
      e = q.pop_front(); n_cmp++; if (rs1_b !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, rs1_b, e.exp); end
      e = q.pop_front(); n_cmp++; if (32'({rs1_busy_a, rs2_busy_a, rs1_busy_b}) !== e.exp) begin n_bad++; $display("FAIL %s: got %b want %b", e.name, {rs1_busy_a, rs2_busy_a, rs1_busy_b}, e.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the OTTER register file for the pipelined core. Adds synchronous clear, an optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register scoreboard of pending writes with a flush input and an occupancy count.
- Sits between decode (read/issue) and writeback; the hazard unit consumes the busy outputs.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2.
- AW, $clog2(NREGS), address width; derived, do not override.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- adr1  in  AW  read address, port 1
- adr2  in  AW  read address, port 2
- rs1  out  XLEN  read data, port 1 (combinational)
- rs2  out  XLEN  read data, port 2 (combinational)
- rs1_busy  out  1  register at adr1 has a pending write
- rs2_busy  out  1  register at adr2 has a pending write
- issue_en  in  1  mark issue_rd as pending
- issue_rd  in  AW  destination of the issuing instruction
- en  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  XLEN  writeback data
- flush  in  1  cancel all pending marks
- pend_cnt  out  AW+1  number of busy bits set

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. rst high at a rising edge clears all registers to 0, all busy bits to 0 and pend_cnt to 0. It overrides en, issue_en and flush that cycle.
- After reset: rs1 = rs2 = 0, rs1_busy = rs2_busy = 0, pend_cnt = 0.
- Reset mid-operation: any pending marks and in-flight data are discarded; nothing is written.
- Writable register: wa != 0, or ZERO_REG = 0.
- Write: at the rising edge, if en is high and wa is writable, reg[wa] <= wd. Writes to register 0 are dropped silently when ZERO_REG = 1.
- Reads are asynchronous. rsN = 0 if ZERO_REG = 1 and adrN = 0.
  - Else, if BYPASS = 1, en is high, wa = adrN and wa is writable, rsN = wd (write-first).
  - Else rsN = reg[adrN].
  - With BYPASS = 0, the new value is visible only after the edge.
- Scoreboard, one busy bit per register, updated at the rising edge in priority order:
  1. rst clears all bits.
  2. flush clears all bits; issue_en that cycle is ignored. A data write with en is still performed.
  3. en with a writable wa clears busy[wa].
  4. issue_en with a writable issue_rd sets busy[issue_rd]. If issue_rd = wa in the same cycle, the set wins (new producer).
- Issue to register 0 when ZERO_REG = 1 is ignored. Writeback to a register that is not busy still writes data and leaves the bit clear.
- rsN_busy = busy[adrN], AND NOT (BYPASS = 1, en, wa = adrN, wa writable). The bypass hides a pending bit whose producer is writing back this cycle. rsN_busy is always 0 for register 0 when ZERO_REG = 1.
- pend_cnt is a registered population count of the busy bits. It reflects the state after the most recent edge, so it lags issue/writeback by one cycle. Maximum is NREGS (NREGS - 1 with ZERO_REG = 1); no overflow is possible.
- No X propagation: all registers have defined values from reset; initial blocks are not relied on.

Test Plan:
1. Reset, then write reg 5 = 0xDEADBEEF (en = 1). Read reg 5 on both ports in the same cycle and the next -> BYPASS = 1: 0xDEADBEEF both cycles; BYPASS = 0: old value 0, then 0xDEADBEEF.
2. en = 1, wa = 0, wd = 0x12345678 with ZERO_REG = 1; then adr1 = 0 -> rs1 = 0, rs1_busy = 0. Repeat with ZERO_REG = 0 -> rs1 = 0x12345678.
3. issue reg 3, reg 7, reg 9 on consecutive cycles -> pend_cnt 1, 2, 3. rs1_busy = 1 at adr1 = 7. Writeback reg 7 with adr1 = 7, BYPASS = 1 -> rs1_busy = 0 that cycle, pend_cnt = 2 next cycle.
4. Same cycle: issue_rd = 4 and wa = 4 with reg 4 busy -> busy[4] stays 1, reg 4 = wd, pend_cnt unchanged.
5. Three regs busy; flush together with issue_en (reg 10) and en (reg 3, 0xA5A5A5A5) -> pend_cnt = 0 next cycle, reg 10 not busy, reg 3 reads 0xA5A5A5A5.
6. Fill registers with non-zero data and busy bits; assert rst for 1 cycle together with en and issue_en -> every register reads 0, all busy = 0, pend_cnt = 0, the write is not performed.
